// File: rtl/i2s_tx_fifo.sv
// I2S / left-justified stereo transmitter with a stereo sample FIFO and derived MCLK/SCK/LRCK.
// Optional underrun counter (underrun_clr / underrun_cnt) is enabled by defining I2S_TX_UNDERRUN_CNT_EN.
module i2s_tx_fifo #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned SLOT_W     = 32,
  parameter int unsigned MCLK_DIV   = 8,
  parameter int unsigned SCK_DIV    = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               in_l,
  input  logic [DATA_W-1:0]               in_r,
  input  logic                            mode,
  input  logic                            mute,
  output logic                            mclk,
  output logic                            sck,
  output logic                            lrck,
  output logic                            sdin,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  input  logic                            underrun_clr,
  output logic [15:0]                     underrun_cnt
`endif
);

  localparam int unsigned CW  = $clog2(SCK_DIV * 2 * SLOT_W);
  localparam int unsigned MB  = $clog2(MCLK_DIV);
  localparam int unsigned SB  = $clog2(SCK_DIV);
  localparam int unsigned FW  = 2 * SLOT_W;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned PAD = SLOT_W - DATA_W;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FW-1:0]     shift_q, shift_d;
  logic              sdin_q, sdin_d;
  logic              underrun_q, underrun_d;
  logic              in_ready_q, in_ready_d;
  logic [LW-1:0]     level_q, level_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [DATA_W-1:0] mem_l_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_r_q [FIFO_DEPTH];

  logic              load;
  logic              sck_fall;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [FW-1:0]     lj_frame;

  // Frame timing, shifter and FIFO bookkeeping
  always_comb begin
    cnt_d      = cnt_q + CW'(1);
    load       = (cnt_q == '0);
    sck_fall   = &cnt_q[SB-1:0];
    fifo_empty = (level_q == '0);
    push       = in_valid && in_ready_q;
    pop        = load && !fifo_empty;
    lj_frame   = {mem_l_q[rptr_q], {PAD{1'b0}}, mem_r_q[rptr_q], {PAD{1'b0}}};

    shift_d    = shift_q;
    sdin_d     = shift_q[FW-1];
    underrun_d = load && fifo_empty;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;

    // I2S frame is the left-justified frame delayed by one SCK
    if (load) begin
      if (fifo_empty || mute) shift_d = '0;
      else if (mode)          shift_d = lj_frame;
      else                    shift_d = lj_frame >> 1;
    end else if (sck_fall) begin
      shift_d = {shift_q[FW-2:0], 1'b0};
    end

    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    in_ready_d = (level_d != LW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      shift_q    <= '0;
      sdin_q     <= 1'b0;
      underrun_q <= 1'b0;
      in_ready_q <= 1'b1;
      level_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      sdin_q     <= sdin_d;
      underrun_q <= underrun_d;
      in_ready_q <= in_ready_d;
      level_q    <= level_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // Sample storage; contents are discarded on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_l_q <= '{default: '0};
      mem_r_q <= '{default: '0};
    end else if (push) begin
      mem_l_q[wptr_q] <= in_l;
      mem_r_q[wptr_q] <= in_r;
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating underrun counter; clear has priority
  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_clr)                         ucnt_d = '0;
    else if (underrun_d && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ucnt_q <= '0;
    else        ucnt_q <= ucnt_d;
  end

  assign underrun_cnt = ucnt_q;
`endif

  assign mclk       = cnt_q[MB-1];
  assign sck        = cnt_q[SB-1];
  assign lrck       = cnt_q[CW-1];
  assign sdin       = sdin_q;
  assign underrun   = underrun_q;
  assign in_ready   = in_ready_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Directed bench for i2s_tx_fifo at default parameters: frame content, clock ratios, FIFO flow,
// mute, underrun and asynchronous reset; underrun counter checks when I2S_TX_UNDERRUN_CNT_EN is defined.
module tb_i2s_tx_fifo;

  localparam int unsigned DW = 24;
  localparam int unsigned LW = 3;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_l;
  logic [DW-1:0] in_r;
  logic          mode;
  logic          mute;
  logic          mclk;
  logic          sck;
  logic          lrck;
  logic          sdin;
  logic [LW-1:0] fifo_level;
  logic          underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic          underrun_clr;
  logic [15:0]   underrun_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int e     = 0;
  pair_t pend[$];
  pair_t exp_q[$];

  i2s_tx_fifo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_l       (in_l),
    .in_r       (in_r),
    .mode       (mode),
    .mute       (mute),
    .mclk       (mclk),
    .sck        (sck),
    .lrck       (lrck),
    .sdin       (sdin),
    .fifo_level (fifo_level),
    .underrun   (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_clr (underrun_clr),
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  // Serial bit k of a frame: I2S puts L MSB at bit 1 and R MSB at bit 33; LJ at bits 0 and 32
  function automatic logic [63:0] exp_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                                            input logic lj);
    logic [63:0] w;
    int off;
    w   = '0;
    off = lj ? 0 : 1;
    for (int k = 0; k < 64; k++) begin
      if (k >= off && k < off + 24)           w[63-k] = l[23-(k-off)];
      else if (k >= 32 + off && k < 56 + off) w[63-k] = r[23-(k-32-off)];
    end
    return w;
  endfunction

  // One full frame starting just before its load edge; pushes pending pairs after the load edge
  task automatic capture(input string tag);
    logic [63:0] sd, lr, exp_sd;
    int nm, ns, nl, nu, exp_lvl;
    logic u1, exp_u, pm, ps, pl, acc;
    logic [LW-1:0] lvl;
    pair_t p;
    if (exp_q.size() > 0) begin
      p      = exp_q.pop_front();
      exp_sd = mute ? 64'h0 : exp_frame(p.l, p.r, mode);
      exp_u  = 1'b0;
    end else begin
      exp_sd = 64'h0;
      exp_u  = 1'b1;
    end
    exp_lvl = exp_q.size();
    sd = '0; lr = '0; nm = 0; ns = 0; nl = 0; nu = 0; u1 = 1'b0; lvl = '0;
    pm = mclk; ps = sck; pl = lrck;
    for (int s = 1; s <= 2048; s++) begin
      in_valid = (s >= 2) && (pend.size() > 0);
      if (in_valid) begin
        in_l = pend[0].l;
        in_r = pend[0].r;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) exp_q.push_back(pend.pop_front());
      if (s == 1) begin
        u1  = underrun;
        lvl = fifo_level;
      end
      nu += int'(underrun);
      if (mclk && !pm) nm++;
      if (sck && !ps)  ns++;
      if (lrck && !pl) nl++;
      pm = mclk; ps = sck; pl = lrck;
      if (s % 32 == 16) begin
        sd[63 - s/32] = sdin;
        lr[63 - s/32] = lrck;
      end
    end
    in_valid = 1'b0;
    check({tag, ".sdin"}, sd, exp_sd);
    check({tag, ".lrck"}, lr, 64'h0000_0000_FFFF_FFFF);
    check({tag, ".clkrises"}, 64'({16'(nm), 16'(ns), 16'(nl)}), 64'h0100_0040_0001);
    check({tag, ".underrun"}, 64'({u1, 8'(nu)}), 64'({exp_u, 8'(exp_u)}));
    check({tag, ".level"}, 64'(lvl), 64'(exp_lvl));
  endtask

  initial begin
    in_valid = 1'b0;
    in_l     = '0;
    in_r     = '0;
    mode     = 1'b0;
    mute     = 1'b0;
    rst_n    = 1'b0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    underrun_clr = 1'b0;
`endif
    #23;
    check("reset_outputs", 64'({mclk, sck, lrck, sdin, underrun, in_ready, fifo_level}),
          64'(9'b0000_0100_0));
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("reset_ucnt", 64'(underrun_cnt), 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;

    // Frame 0 underruns; pair pushed during it plays as I2S in frame 1
    pend.push_back('{l: 24'hA5A5A5, r: 24'h5A5A5A});
    capture("f0_empty");
    pend.push_back('{l: 24'hA5A5A5, r: 24'h5A5A5A});
    capture("f1_i2s");
    mode = 1'b1;
    for (int i = 1; i <= 5; i++)
      pend.push_back('{l: 24'(24'h111111 * i), r: 24'(~(24'h111111 * i))});
    capture("f2_lj");
    check("full_ready_level", 64'({in_ready, fifo_level}), 64'({1'b0, 3'd4}));
    mode = 1'b0;
    capture("f3_pair1");
    mode = 1'b1;
    capture("f4_pair2");
    mode = 1'b0;
    capture("f5_pair3");
    check("two_queued", 64'(fifo_level), 64'd2);

    // Muted frames still pop the FIFO
    mute = 1'b1;
    capture("f6_mute");
    capture("f7_mute");
    capture("f8_mute_empty");
    mute = 1'b0;

    pend.push_back('{l: 24'hC0FFEE, r: 24'h123456});
    pend.push_back('{l: 24'h800001, r: 24'h7FFFFE});
    capture("f9_empty_fill");
    for (int i = 0; i < 700; i++) step();
    check("pre_reset_cnt700", 64'({mclk, sck, lrck, fifo_level}), 64'({3'b110, 3'd1}));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 64'({mclk, sck, lrck, sdin, underrun, in_ready, fifo_level}),
          64'(9'b0000_0100_0));
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", 64'({mclk, sck, lrck, sdin, underrun, in_ready, fifo_level}),
          64'(9'b0000_0100_0));
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("ucnt_after_reset", 64'(underrun_cnt), 64'h0);
`endif
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    capture("r0_empty");
    capture("r1_empty");
    capture("r2_empty");
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("ucnt_three", 64'(underrun_cnt), 64'd3);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("ucnt_clear_wins", 64'({underrun, underrun_cnt}), 64'({1'b1, 16'h0}));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
